// File: rtl/mem_stage_sram_pkg.sv
// Shared types and constants for the SRAM-backed MEM stage.
// Optional stall counter is enabled with MEM_STALL_CNT_EN.
package mem_stage_sram_pkg;

  localparam int unsigned SramDw          = 16;
  localparam int unsigned DefaultBaseAddr = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StDone
  } mem_state_e;

  function automatic int unsigned phase_width(input int unsigned wait_cycles);
    return (wait_cycles == 0) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// Two-phase halfword SRAM sequencer: FSM, phase counter, SRAM pins and the {hi,lo} result register.
// The request cycle in StIdle doubles as the first cycle of the lo phase.
module mem_stage_sram_ctrl
  import mem_stage_sram_pkg::*;
#(
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  input  logic               write_i,
  input  logic               clr_i,
  input  logic [SRAM_AW-2:0] word_i,
  input  logic [31:0]        wdata_i,
  input  logic [SramDw-1:0]  sram_dq_i,
  output logic               freeze_o,
  output logic [31:0]        result_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [SramDw-1:0]  sram_dq_o,
  output logic               sram_oe_o,
  output logic               sram_we_n_o
);

  localparam int unsigned PhW = phase_width(WAIT_CYCLES);
  localparam logic [PhW-1:0] PhLast = PhW'(WAIT_CYCLES);

  mem_state_e     state_q;
  logic [PhW-1:0] phase_q;
  logic [31:0]    result_q;
  logic           start, lo_sel, hi_sel, active, drive;

  // Gate with reset so the pins fall back to idle values while reset is held.
  assign start  = rst_ni && (state_q == StIdle) && req_i;
  assign lo_sel = start || (state_q == StLo);
  assign hi_sel = (state_q == StHi);
  assign active = lo_sel || hi_sel;
  assign drive  = active && write_i;

  assign freeze_o    = active;
  assign sram_addr_o = active ? {word_i, hi_sel} : '0;
  assign sram_dq_o   = drive ? (hi_sel ? wdata_i[31:16] : wdata_i[15:0]) : '0;
  assign sram_oe_o   = drive;
  assign sram_we_n_o = !drive;
  assign result_o    = result_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          phase_q <= '0;
          if (req_i) begin
            if (WAIT_CYCLES == 0) begin
              state_q <= StHi;
              if (!write_i) result_q[15:0] <= sram_dq_i;
            end else begin
              state_q <= StLo;
              phase_q <= PhW'(1);
            end
          end else if (clr_i) begin
            result_q <= '0;
          end
        end
        StLo: begin
          if (phase_q == PhLast) begin
            state_q <= StHi;
            phase_q <= '0;
            if (!write_i) result_q[15:0] <= sram_dq_i;
          end else begin
            phase_q <= phase_q + PhW'(1);
          end
        end
        StHi: begin
          if (phase_q == PhLast) begin
            state_q <= StDone;
            phase_q <= '0;
            if (!write_i) result_q[31:16] <= sram_dq_i;
          end else begin
            phase_q <= phase_q + PhW'(1);
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage_sram.sv
// MEM stage with off-chip 16-bit SRAM: range check, address mapping, pass-through and sequencer.
// Define MEM_STALL_CNT_EN to add the saturating stall_cnt output.
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DefaultBaseAddr,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        PC_in,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic               wb_enable_in,
  input  logic [3:0]         wb_dest_in,
  input  logic [31:0]        ALU_result_in,
  input  logic [31:0]        val_Rm_in,
  output logic [31:0]        PC_out,
  output logic               mem_read_out,
  output logic               wb_enable_out,
  output logic [3:0]         wb_dest_out,
  output logic [31:0]        ALU_result_out,
  output logic [31:0]        mem_result_out,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SramDw-1:0]  sram_dq_o,
  input  logic [SramDw-1:0]  sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  logic [31:0] offset;
  logic        mem_op, in_range;
  logic        unused_offset_lsb;

  assign offset            = ALU_result_in - BASE_ADDR;
  assign unused_offset_lsb = ^offset[1:0];
  assign mem_op            = mem_read_in || mem_write_in;
  // Word index must fit in SRAM_AW-1 bits, i.e. offset bits above SRAM_AW are clear.
  assign in_range          = (ALU_result_in >= BASE_ADDR) && (offset[31:SRAM_AW+1] == '0);

  assign PC_out         = PC_in;
  assign mem_read_out   = mem_read_in;
  assign wb_enable_out  = wb_enable_in;
  assign wb_dest_out    = wb_dest_in;
  assign ALU_result_out = ALU_result_in;

  mem_stage_sram_ctrl #(
    .SRAM_AW     (SRAM_AW),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_ctrl (
    .clk_i       (clk),
    .rst_ni      (rst),
    .req_i       (mem_op && in_range),
    .write_i     (mem_write_in),
    .clr_i       (mem_op && !in_range),
    .word_i      (offset[SRAM_AW:2]),
    .wdata_i     (val_Rm_in),
    .sram_dq_i   (sram_dq_i),
    .freeze_o    (freeze),
    .result_o    (mem_result_out),
    .sram_addr_o (sram_addr),
    .sram_dq_o   (sram_dq_o),
    .sram_oe_o   (sram_dq_oe),
    .sram_we_n_o (sram_we_n)
  );

`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (freeze && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage_sram.sv
// Self-checking bench for mem_stage_sram with a behavioural async SRAM and a load-result scoreboard.
module tb_mem_stage_sram;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_in, ALU_result_in, val_Rm_in;
  logic        mem_read_in, mem_write_in, wb_enable_in;
  logic [3:0]  wb_dest_in;
  logic [31:0] PC_out, ALU_result_out, mem_result_out;
  logic        mem_read_out, wb_enable_out, freeze;
  logic [3:0]  wb_dest_out;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_we_n;
`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  logic [15:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_a = '0;
  logic [15:0] pre_d = '0;
  int          wr_cnt = 0;
  int          nvec = 0, nerr = 0, exp_stall = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result;

  always #5 clk = ~clk;

  mem_stage_sram #(
    .BASE_ADDR   (1024),
    .SRAM_AW     (18),
    .WAIT_CYCLES (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .PC_in          (PC_in),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .wb_enable_in   (wb_enable_in),
    .wb_dest_in     (wb_dest_in),
    .ALU_result_in  (ALU_result_in),
    .val_Rm_in      (val_Rm_in),
    .PC_out         (PC_out),
    .mem_read_out   (mem_read_out),
    .wb_enable_out  (wb_enable_out),
    .wb_dest_out    (wb_dest_out),
    .ALU_result_out (ALU_result_out),
    .mem_result_out (mem_result_out),
    .freeze         (freeze),
    .sram_addr      (sram_addr),
    .sram_dq_o      (sram_dq_o),
    .sram_dq_i      (sram_dq_i),
    .sram_dq_oe     (sram_dq_oe),
    .sram_we_n      (sram_we_n)
`ifdef MEM_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  // Asynchronous-read SRAM; only the low 10 address bits are modelled.
  assign sram_dq_i = mem[sram_addr[9:0]];

  always @(posedge clk) begin
    if (!sram_we_n) begin
      mem[sram_addr[9:0]] <= sram_dq_o;
      wr_cnt <= wr_cnt + 1;
    end else if (pre_we) begin
      mem[pre_a] <= pre_d;
    end
  end

  task automatic nop();
    PC_in = '0; ALU_result_in = '0; val_Rm_in = '0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; wb_enable_in = 1'b0; wb_dest_in = '0;
  endtask

  task automatic preset(input logic [9:0] a, input logic [15:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic check_stall(input string name);
`ifdef MEM_STALL_CNT_EN
    nvec++;
    if (stall_cnt !== 32'(exp_stall)) begin
      nerr++;
      $display("FAIL %s stall_cnt: got %0d want %0d", name, stall_cnt, exp_stall);
    end
`endif
  endtask

  // Runs one in-range access starting at posedge+1; leaves nop driven at the advancing edge.
  task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_rd, input string name);
    logic [17:0] lo_a;
    logic [31:0] pc, exp_v;
    int          cycles, wr0;
    bit          done;
    lo_a = 18'(((addr - 32'd1024) >> 2) << 1);
    pc   = $urandom;
    wr0  = wr_cnt;
    PC_in = pc; ALU_result_in = addr; val_Rm_in = data;
    mem_read_in = !wr; mem_write_in = wr; wb_enable_in = !wr; wb_dest_in = addr[5:2];
    if (!wr) exp_q.push_back(exp_rd);
    cycles = 0;
    done   = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!freeze) begin
        done = 1'b1;
      end else begin
        nvec++;
        if (sram_addr !== ((cycles < 2) ? lo_a : lo_a + 18'd1)) begin
          nerr++;
          $display("FAIL %s addr cyc%0d: got %h want %h", name, cycles, sram_addr,
                   (cycles < 2) ? lo_a : lo_a + 18'd1);
        end
        nvec++;
        if (wr) begin
          if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1 ||
              sram_dq_o !== ((cycles < 2) ? data[15:0] : data[31:16])) begin
            nerr++;
            $display("FAIL %s write pins cyc%0d: got we_n=%b oe=%b dq=%h want 0 1 %h", name,
                     cycles, sram_we_n, sram_dq_oe, sram_dq_o,
                     (cycles < 2) ? data[15:0] : data[31:16]);
          end
        end else if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
          nerr++;
          $display("FAIL %s read pins cyc%0d: got we_n=%b oe=%b want 1 0", name, cycles,
                   sram_we_n, sram_dq_oe);
        end
        cycles++;
        @(posedge clk);
      end
    end
    nvec++;
    if (cycles != 4) begin
      nerr++;
      $display("FAIL %s freeze length: got %0d want 4", name, cycles);
    end
    nvec++;
    if (PC_out !== pc || ALU_result_out !== addr || mem_read_out !== !wr ||
        wb_enable_out !== !wr || wb_dest_out !== addr[5:2]) begin
      nerr++;
      $display("FAIL %s pass-through: got pc=%h alu=%h want pc=%h alu=%h", name, PC_out,
               ALU_result_out, pc, addr);
    end
    if (!wr) begin
      exp_v = exp_q.pop_front();
      last_result = exp_v;
      nvec++;
      if (mem_result_out !== exp_v) begin
        nerr++;
        $display("FAIL %s load data: got %h want %h", name, mem_result_out, exp_v);
      end
    end else begin
      nvec++;
      if (wr_cnt - wr0 != 4) begin
        nerr++;
        $display("FAIL %s write count: got %0d want 4", name, wr_cnt - wr0);
      end
    end
    exp_stall += 4;
    check_stall(name);
    @(posedge clk); #1;
    nop();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    nop();
    mem_read_in = 1'b1; ALU_result_in = 32'd1028;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (freeze !== 1'b0 || mem_result_out !== '0 || sram_addr !== '0 || sram_dq_o !== '0 ||
        sram_dq_oe !== 1'b0 || sram_we_n !== 1'b1) begin
      nerr++;
      $display("FAIL reset state: got frz=%b res=%h a=%h dq=%h oe=%b we_n=%b want 0 0 0 0 0 1",
               freeze, mem_result_out, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n);
    end
    exp_stall = 0;
    last_result = '0;
    check_stall("reset");
    nop();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    preset(10'd2, 16'hBEEF);
    preset(10'd3, 16'hDEAD);
    do_access(1'b0, 32'd1028, 32'h0, 32'hDEADBEEF, "load");
  endtask

  task automatic test_store();
    do_access(1'b1, 32'd1024, 32'h12345678, 32'h0, "store");
    do_access(1'b0, 32'd1024, 32'h0, 32'h12345678, "store_readback");
  endtask

  task automatic test_out_of_range();
    int wr0;
    wr0 = wr_cnt;
    mem_read_in = 1'b1; ALU_result_in = 32'd512;
    #1;
    nvec++;
    if (freeze !== 1'b0 || sram_we_n !== 1'b1 || sram_addr !== '0) begin
      nerr++;
      $display("FAIL oor_low pins: got frz=%b we_n=%b a=%h want 0 1 0", freeze, sram_we_n,
               sram_addr);
    end
    @(posedge clk); #1;
    last_result = '0;
    nvec++;
    if (mem_result_out !== last_result) begin
      nerr++;
      $display("FAIL oor_low result: got %h want %h", mem_result_out, last_result);
    end
    // First word past the end of an 18-bit halfword SRAM.
    mem_read_in = 1'b0; mem_write_in = 1'b1; ALU_result_in = 32'd525312; val_Rm_in = 32'hFFFF;
    #1;
    nvec++;
    if (freeze !== 1'b0 || sram_we_n !== 1'b1) begin
      nerr++;
      $display("FAIL oor_high pins: got frz=%b we_n=%b want 0 1", freeze, sram_we_n);
    end
    @(posedge clk); #1;
    nvec++;
    if (wr_cnt != wr0) begin
      nerr++;
      $display("FAIL oor writes: got %0d want 0", wr_cnt - wr0);
    end
    check_stall("oor");
    nop();
    // Last in-range word: address bits must reach the top of the SRAM.
    do_access(1'b1, 32'd525308, 32'hA5A5_5A5A, 32'h0, "top_word");
  endtask

  task automatic test_passthrough();
    logic [31:0] pc, alu;
    pc = $urandom; alu = $urandom;
    PC_in = pc; ALU_result_in = alu; wb_enable_in = 1'b1; wb_dest_in = 4'hA;
    #1;
    nvec++;
    if (PC_out !== pc || ALU_result_out !== alu || wb_enable_out !== 1'b1 ||
        wb_dest_out !== 4'hA || mem_read_out !== 1'b0 || freeze !== 1'b0) begin
      nerr++;
      $display("FAIL nonmem pass-through: got pc=%h alu=%h frz=%b want pc=%h alu=%h frz=0",
               PC_out, ALU_result_out, freeze, pc, alu);
    end
    @(posedge clk); #1;
    nvec++;
    if (mem_result_out !== last_result) begin
      nerr++;
      $display("FAIL nonmem result hold: got %h want %h", mem_result_out, last_result);
    end
    nop();
  endtask

  task automatic test_back_to_back();
    preset(10'd30, 16'h1111);
    preset(10'd31, 16'h2222);
    preset(10'd32, 16'h3333);
    preset(10'd33, 16'h4444);
    do_access(1'b0, 32'd1084, 32'h0, 32'h2222_1111, "b2b_first");
    do_access(1'b0, 32'd1088, 32'h0, 32'h4444_3333, "b2b_second");
  endtask

  task automatic test_reset_mid_store();
    int wr0;
    preset(10'd20, 16'hAAAA);
    preset(10'd21, 16'h5555);
    wr0 = wr_cnt;
    mem_write_in = 1'b1; ALU_result_in = 32'd1064; val_Rm_in = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    nvec++;
    if (sram_addr !== 18'd21 || freeze !== 1'b1) begin
      nerr++;
      $display("FAIL rst_mid hi phase: got a=%h frz=%b want 15 1", sram_addr, freeze);
    end
    rst = 1'b0;
    nop();
    #1;
    exp_stall = 0;
    last_result = '0;
    nvec++;
    if (freeze !== 1'b0 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== '0 ||
        sram_dq_o !== '0 || mem_result_out !== '0) begin
      nerr++;
      $display("FAIL rst_mid outputs: got frz=%b we_n=%b oe=%b a=%h dq=%h res=%h", freeze,
               sram_we_n, sram_dq_oe, sram_addr, sram_dq_o, mem_result_out);
    end
    @(posedge clk); #1;
    nvec++;
    if (mem[21] !== 16'h5555 || mem[20] !== 16'hF00D || wr_cnt - wr0 != 2) begin
      nerr++;
      $display("FAIL rst_mid sram: got hi=%h lo=%h writes=%0d want 5555 f00d 2", mem[21],
               mem[20], wr_cnt - wr0);
    end
    check_stall("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    do_access(1'b0, 32'd1064, 32'h0, 32'h5555_F00D, "rst_mid_readback");
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_out_of_range();
    test_passthrough();
    test_back_to_back();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
